// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush and saturating perf counters
// A flush loads a canonical all-zero NOP; an upstream bubble keeps data but drops side effects.
module id_ex_reg #(
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iStall,
    input  logic          iFlush,
    input  logic          iValid,
    input  logic [DW-1:0] iPC,
    input  logic [DW-1:0] iRsData,
    input  logic [DW-1:0] iRtData,
    input  logic [DW-1:0] iImm,
    input  logic [4:0]    iRs,
    input  logic [4:0]    iRt,
    input  logic [4:0]    iRd,
    input  logic [4:0]    iShamt,
    input  logic [3:0]    iALUC,
    input  logic          iALUSrc,
    input  logic          iRegDst,
    input  logic          iRegWrite,
    input  logic          iMemRead,
    input  logic          iMemWrite,
    input  logic          iMemToReg,
    output logic          oValid,
    output logic [DW-1:0] oPC,
    output logic [DW-1:0] oRsData,
    output logic [DW-1:0] oRtData,
    output logic [DW-1:0] oImm,
    output logic [4:0]    oRs,
    output logic [4:0]    oRt,
    output logic [4:0]    oRd,
    output logic [4:0]    oShamt,
    output logic [3:0]    oALUC,
    output logic          oALUSrc,
    output logic          oRegDst,
    output logic          oRegWrite,
    output logic          oMemRead,
    output logic          oMemWrite,
    output logic          oMemToReg,
    output logic [CW-1:0] oStallCnt,
    output logic [CW-1:0] oBubbleCnt
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oValid     <= 1'b0;
            oPC        <= '0;
            oRsData    <= '0;
            oRtData    <= '0;
            oImm       <= '0;
            oRs        <= '0;
            oRt        <= '0;
            oRd        <= '0;
            oShamt     <= '0;
            oALUC      <= '0;
            oALUSrc    <= 1'b0;
            oRegDst    <= 1'b0;
            oRegWrite  <= 1'b0;
            oMemRead   <= 1'b0;
            oMemWrite  <= 1'b0;
            oMemToReg  <= 1'b0;
            oStallCnt  <= '0;
            oBubbleCnt <= '0;
        end else if (iFlush) begin
            // Zeroed specifiers keep forwarding from ever matching a bubble
            oValid     <= 1'b0;
            oPC        <= '0;
            oRsData    <= '0;
            oRtData    <= '0;
            oImm       <= '0;
            oRs        <= '0;
            oRt        <= '0;
            oRd        <= '0;
            oShamt     <= '0;
            oALUC      <= '0;
            oALUSrc    <= 1'b0;
            oRegDst    <= 1'b0;
            oRegWrite  <= 1'b0;
            oMemRead   <= 1'b0;
            oMemWrite  <= 1'b0;
            oMemToReg  <= 1'b0;
            if (oBubbleCnt != CNT_MAX)
                oBubbleCnt <= oBubbleCnt + CNT_ONE;
        end else if (iStall) begin
            if (oStallCnt != CNT_MAX)
                oStallCnt <= oStallCnt + CNT_ONE;
        end else begin
            oValid     <= iValid;
            oPC        <= iPC;
            oRsData    <= iRsData;
            oRtData    <= iRtData;
            oImm       <= iImm;
            oRs        <= iRs;
            oRt        <= iRt;
            oRd        <= iRd;
            oShamt     <= iShamt;
            oALUC      <= iALUC;
            oALUSrc    <= iALUSrc;
            oRegDst    <= iRegDst;
            oRegWrite  <= iRegWrite & iValid;
            oMemRead   <= iMemRead & iValid;
            oMemWrite  <= iMemWrite & iValid;
            oMemToReg  <= iMemToReg;
            if (!iValid && oBubbleCnt != CNT_MAX)
                oBubbleCnt <= oBubbleCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed and randomized checks of id_ex_reg against a field-level model
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iStall = 0, iFlush = 0, iValid = 0;
    logic [31:0] iPC = 0, iRsData = 0, iRtData = 0, iImm = 0;
    logic [4:0]  iRs = 0, iRt = 0, iRd = 0, iShamt = 0;
    logic [3:0]  iALUC = 0;
    logic        iALUSrc = 0, iRegDst = 0, iRegWrite = 0, iMemRead = 0, iMemWrite = 0, iMemToReg = 0;

    logic        oValid, oALUSrc, oRegDst, oRegWrite, oMemRead, oMemWrite, oMemToReg;
    logic [31:0] oPC, oRsData, oRtData, oImm, oStallCnt, oBubbleCnt;
    logic [4:0]  oRs, oRt, oRd, oShamt;
    logic [3:0]  oALUC;

    logic        sValid, sALUSrc, sRegDst, sRegWrite, sMemRead, sMemWrite, sMemToReg;
    logic [31:0] sPC, sRsData, sRtData, sImm;
    logic [4:0]  sRs, sRt, sRd, sShamt;
    logic [3:0]  sALUC, sStallCnt, sBubbleCnt;

    int errors = 0;
    int checks = 0;

    // Reference state: one snapshot of what EX should see, plus counter totals
    logic        m_valid, m_alusrc, m_regdst, m_regwrite, m_memread, m_memwrite, m_memtoreg;
    logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
    logic [3:0]  m_aluc;
    longint      m_stall, m_bub, m_sstall, m_sbub;

    always #5 clk = ~clk;

    id_ex_reg #(.DW(32), .CW(32)) u_dut (
        .clk(clk), .rst(rst), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
        .iPC(iPC), .iRsData(iRsData), .iRtData(iRtData), .iImm(iImm),
        .iRs(iRs), .iRt(iRt), .iRd(iRd), .iShamt(iShamt), .iALUC(iALUC),
        .iALUSrc(iALUSrc), .iRegDst(iRegDst), .iRegWrite(iRegWrite),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .oValid(oValid), .oPC(oPC), .oRsData(oRsData), .oRtData(oRtData), .oImm(oImm),
        .oRs(oRs), .oRt(oRt), .oRd(oRd), .oShamt(oShamt), .oALUC(oALUC),
        .oALUSrc(oALUSrc), .oRegDst(oRegDst), .oRegWrite(oRegWrite),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemToReg(oMemToReg),
        .oStallCnt(oStallCnt), .oBubbleCnt(oBubbleCnt)
    );

    id_ex_reg #(.DW(32), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
        .iPC(iPC), .iRsData(iRsData), .iRtData(iRtData), .iImm(iImm),
        .iRs(iRs), .iRt(iRt), .iRd(iRd), .iShamt(iShamt), .iALUC(iALUC),
        .iALUSrc(iALUSrc), .iRegDst(iRegDst), .iRegWrite(iRegWrite),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .oValid(sValid), .oPC(sPC), .oRsData(sRsData), .oRtData(sRtData), .oImm(sImm),
        .oRs(sRs), .oRt(sRt), .oRd(sRd), .oShamt(sShamt), .oALUC(sALUC),
        .oALUSrc(sALUSrc), .oRegDst(sRegDst), .oRegWrite(sRegWrite),
        .oMemRead(sMemRead), .oMemWrite(sMemWrite), .oMemToReg(sMemToReg),
        .oStallCnt(sStallCnt), .oBubbleCnt(sBubbleCnt)
    );

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_clear_fields();
        m_valid = 0; m_pc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_shamt = 0; m_aluc = 0;
        m_alusrc = 0; m_regdst = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_memtoreg = 0;
    endtask

    task automatic model_reset();
        model_clear_fields();
        m_stall = 0; m_bub = 0; m_sstall = 0; m_sbub = 0;
    endtask

    // Behaviour of one rising edge with rst low, in priority order flush > stall > load
    task automatic model_edge();
        if (iFlush) begin
            model_clear_fields();
            m_bub  = sat_inc(m_bub, 64'hFFFF_FFFF);
            m_sbub = sat_inc(m_sbub, 15);
        end else if (iStall) begin
            m_stall  = sat_inc(m_stall, 64'hFFFF_FFFF);
            m_sstall = sat_inc(m_sstall, 15);
        end else begin
            m_valid = iValid; m_pc = iPC; m_rs_data = iRsData; m_rt_data = iRtData; m_imm = iImm;
            m_rs = iRs; m_rt = iRt; m_rd = iRd; m_shamt = iShamt; m_aluc = iALUC;
            m_alusrc = iALUSrc; m_regdst = iRegDst; m_memtoreg = iMemToReg;
            m_regwrite = iValid ? iRegWrite : 1'b0;
            m_memread  = iValid ? iMemRead  : 1'b0;
            m_memwrite = iValid ? iMemWrite : 1'b0;
            if (!iValid) begin
                m_bub  = sat_inc(m_bub, 64'hFFFF_FFFF);
                m_sbub = sat_inc(m_sbub, 15);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(oValid), 64'(m_valid));
        chk({tag, ".pc"}, 64'(oPC), 64'(m_pc));
        chk({tag, ".rs_data"}, 64'(oRsData), 64'(m_rs_data));
        chk({tag, ".rt_data"}, 64'(oRtData), 64'(m_rt_data));
        chk({tag, ".imm"}, 64'(oImm), 64'(m_imm));
        chk({tag, ".specs"}, 64'({oRs, oRt, oRd, oShamt}), 64'({m_rs, m_rt, m_rd, m_shamt}));
        chk({tag, ".aluc"}, 64'(oALUC), 64'(m_aluc));
        chk({tag, ".ctrl"}, 64'({oALUSrc, oRegDst, oRegWrite, oMemRead, oMemWrite, oMemToReg}),
            64'({m_alusrc, m_regdst, m_regwrite, m_memread, m_memwrite, m_memtoreg}));
        chk({tag, ".stall_cnt"}, 64'(oStallCnt), 64'(m_stall));
        chk({tag, ".bubble_cnt"}, 64'(oBubbleCnt), 64'(m_bub));
        chk({tag, ".sat_stall_cnt"}, 64'(sStallCnt), 64'(m_sstall));
        chk({tag, ".sat_bubble_cnt"}, 64'(sBubbleCnt), 64'(m_sbub));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        iStall = 0; iFlush = 0; iValid = 0;
        iPC = 0; iRsData = 0; iRtData = 0; iImm = 0;
        iRs = 0; iRt = 0; iRd = 0; iShamt = 0; iALUC = 0;
        iALUSrc = 0; iRegDst = 0; iRegWrite = 0; iMemRead = 0; iMemWrite = 0; iMemToReg = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        iStall = ($urandom_range(0, 3) == 0);
        iFlush = ($urandom_range(0, 7) == 0);
        iValid = ($urandom_range(0, 3) != 0);
        iPC = $urandom; iRsData = $urandom; iRtData = $urandom; iImm = $urandom;
        iRs = 5'($urandom); iRt = 5'($urandom); iRd = 5'($urandom); iShamt = 5'($urandom);
        iALUC = 4'($urandom);
        {iALUSrc, iRegDst, iRegWrite, iMemRead, iMemWrite, iMemToReg} = 6'($urandom);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_state");
        rst = 1'b0;

        // 1: reset lands mid-operation, between edges
        iValid = 1; iPC = 32'h0040_0004; iImm = 32'hFFFF_8000; iRegWrite = 1;
        step("load_before_reset");
        apply_reset();

        // 2: plain one-cycle pass-through
        clear_inputs();
        iValid = 1; iRsData = 32'h1234_5678; iImm = 32'h0000_ABCD; iALUSrc = 1; iRd = 5; iRegWrite = 1;
        step("normal");
        chk("normal.rd_is_5", 64'(oRd), 64'd5);

        // 3: three stall cycles while inputs change
        iStall = 1; iRsData = 32'hDEAD_BEEF; iImm = 32'hDEAD_BEEF; iPC = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) step("stall_hold");
        chk("stall_hold.cnt_is_3", 64'(oStallCnt), 64'd3);
        chk("stall_hold.rs_data_kept", 64'(oRsData), 64'h1234_5678);

        // 4: flush and stall together produce a bubble
        iFlush = 1; iStall = 1; iValid = 1; iMemWrite = 1; iRs = 7;
        step("flush_with_stall");
        chk("flush_with_stall.bubble_is_1", 64'(oBubbleCnt), 64'd1);
        chk("flush_with_stall.stall_still_3", 64'(oStallCnt), 64'd3);

        // 5: upstream bubble keeps data but drops side effects, then is held
        clear_inputs();
        iValid = 0; iRegWrite = 1; iMemRead = 1; iRtData = 32'h55;
        step("upstream_bubble");
        chk("upstream_bubble.rt_data", 64'(oRtData), 64'h55);
        chk("upstream_bubble.bubble_is_2", 64'(oBubbleCnt), 64'd2);
        iStall = 1;
        for (int i = 0; i < 2; i++) step("bubble_held");
        chk("bubble_held.bubble_is_2", 64'(oBubbleCnt), 64'd2);
        chk("bubble_held.stall_is_5", 64'(oStallCnt), 64'd5);

        // 6: 4-bit counter saturates and stays at 0xF
        apply_reset();
        clear_inputs();
        iStall = 1;
        for (int i = 0; i < 20; i++) step("saturate");
        chk("saturate.sat_is_f", 64'(sStallCnt), 64'hF);
        chk("saturate.wide_is_20", 64'(oStallCnt), 64'd20);

        // Randomized traffic against the model
        clear_inputs();
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step("random");
            if (i == 150) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the static 5-stage pipeline.
- Captures the decode-stage results: register-file read data, the 32-bit extended immediate from the 16-bit extender, register specifiers, and ALU/memory/writeback control. Presents them to the EX stage one cycle later.
- Implements stall (hold) and flush (bubble insert).
- Keeps saturating stall and bubble counters for performance debug.

Parameters:
- DW, 32, datapath width (PC, operands, immediate).
- CW, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- iStall  input  1  hold the current contents (EX not ready, or load-use hazard).
- iFlush  input  1  replace the next contents with a bubble (branch/jump taken).
- iValid  input  1  the ID-stage instruction is real (0 = ID already holds a bubble).
- iPC  input  DW  PC+4 of the ID instruction.
- iRsData  input  DW  register-file read port A.
- iRtData  input  DW  register-file read port B.
- iImm  input  DW  extended immediate from the 16-bit extender.
- iRs, iRt, iRd  input  5 each  register specifiers.
- iShamt  input  5  shift amount.
- iALUC  input  4  ALU operation code.
- iALUSrc  input  1  select immediate as ALU operand B.
- iRegDst  input  1  write register is rd (1) or rt (0).
- iRegWrite, iMemRead, iMemWrite, iMemToReg  input  1 each  side-effect controls.
- oValid, oPC, oRsData, oRtData, oImm, oRs, oRt, oRd, oShamt, oALUC, oALUSrc, oRegDst, oRegWrite, oMemRead, oMemWrite, oMemToReg  output  same widths  registered copies of the inputs.
- oStallCnt  output  CW  number of stall cycles.
- oBubbleCnt  output  CW  number of bubbles issued to EX.

Behaviour:
- Reset: rst=1 asynchronously forces every output to 0, including oValid, all controls, data fields and both counters. The register holds that state while rst stays high. Reset asserted mid-stall or mid-flush overrides both.
- Latency: exactly 1 cycle, input to output, when neither stall nor flush is asserted.
- Per-edge priority (rst low): iFlush > iStall > normal load.
- Flush:
  - oValid and all six controls (iALUSrc through iMemToReg) become 0. iALUSrc and iRegDst are cleared as well.
  - oALUC becomes 0.
  - Data and specifier fields also become 0, so EX sees a canonical NOP. Forwarding therefore never matches a bubble's register 0.
- Stall (iFlush=0): every output field holds its value.
- Flush and stall in the same cycle: flush wins and a bubble is loaded. Flush always kills the ID instruction.
- Normal load: all fields are captured from the inputs.
  - If iValid=0, the controls iRegWrite, iMemRead and iMemWrite are captured as 0 regardless of their inputs. oValid=0.
  - Data fields are still captured.
- No side effect may leave this register with oValid=0. Invariant: oValid=0 implies oRegWrite=oMemRead=oMemWrite=0.
- oImm passes through unmodified. No re-extension happens here; sign or zero extension is already resolved upstream.
- oStallCnt:
  - Increments on every edge where iStall=1 and iFlush=0 (and rst=0).
  - Saturates at all-ones and does not wrap.
- oBubbleCnt:
  - Increments on every edge where the newly loaded contents have oValid=0, i.e. either a flush, or a normal load with iValid=0.
  - Saturates at all-ones.
  - Held (stalled) bubbles do not increment it.
- No combinational paths from inputs to outputs.

Test Plan:
1. Reset mid-operation: load iPC=0x00400004, iImm=0xFFFF8000, iRegWrite=1, iValid=1. Assert rst asynchronously between edges -> all outputs, oStallCnt and oBubbleCnt read 0 immediately, before the next edge.
2. Normal pipeline: iValid=1, iRsData=0x12345678, iImm=0x0000ABCD, iALUSrc=1, iRd=5, iRegWrite=1 -> same values on the outputs one edge later. Counters stay 0.
3. Stall hold: with a valid instruction loaded, assert iStall for 3 cycles while the inputs change to 0xDEADBEEF -> outputs are unchanged for 3 cycles. oStallCnt=3. oBubbleCnt=0.
4. Flush with stall: iFlush=1 and iStall=1 together, iValid=1, iMemWrite=1, iRs=7 -> next edge gives oValid=0, oMemWrite=0, oRs=0, oImm=0. oBubbleCnt=1. oStallCnt unchanged.
5. Upstream bubble: iValid=0, iRegWrite=1, iMemRead=1, iRtData=0x55 -> oValid=0, oRegWrite=0, oMemRead=0, oRtData=0x55. oBubbleCnt increments by 1. Holding this bubble with iStall for 2 cycles -> oBubbleCnt unchanged, oStallCnt +2.
6. Saturation: with CW=4, apply 20 consecutive stall cycles -> oStallCnt reaches 0xF and stays 0xF.
